// File: rtl/demux16.sv
// Packet-aware 1-to-16 stream demultiplexer with a one-entry registered output stage.
// The destination is sampled on a packet's first beat and held until the last beat.
module demux16 #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic [3:0]            sel,
    output logic [15:0]           out_valid,
    input  logic [15:0]           out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);

    typedef enum logic [0:0] {StIdle, StLock} state_e;

    state_e                st_q, st_d;
    logic [3:0]            pkt_ch_q, pkt_ch_d;
    logic                  hold_v_q, hold_v_d;
    logic [3:0]            hold_ch_q, hold_ch_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  hold_last_q, hold_last_d;
    logic [15:0]           out_valid_q, out_valid_d;

    logic                  acc;
    logic                  drn;
    logic [3:0]            dest;

    // Ready ignores in_valid and is forced low while reset is asserted.
    assign in_ready = rst_n & (~hold_v_q | out_ready[hold_ch_q]);

    always_comb begin
        acc  = in_valid & in_ready;
        drn  = hold_v_q & out_ready[hold_ch_q];
        dest = (st_q == StLock) ? pkt_ch_q : sel;

        hold_v_d    = hold_v_q;
        hold_ch_d   = hold_ch_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        out_valid_d = out_valid_q;

        // A new beat replaces the held one even when it drains in the same cycle.
        if (acc) begin
            hold_v_d    = 1'b1;
            hold_ch_d   = dest;
            hold_data_d = in_data;
            hold_last_d = in_last;
            out_valid_d = 16'd1 << dest;
        end else if (drn) begin
            hold_v_d    = 1'b0;
            out_valid_d = '0;
        end
    end

    always_comb begin
        st_d     = st_q;
        pkt_ch_d = pkt_ch_q;
        if (acc) begin
            unique case (st_q)
                StIdle: begin
                    if (!in_last) begin
                        st_d     = StLock;
                        pkt_ch_d = sel;
                    end
                end
                StLock: begin
                    if (in_last) begin
                        st_d = StIdle;
                    end
                end
                default: st_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= StIdle;
            pkt_ch_q    <= '0;
            hold_v_q    <= 1'b0;
            hold_ch_q   <= '0;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
            out_valid_q <= '0;
        end else begin
            st_q        <= st_d;
            pkt_ch_q    <= pkt_ch_d;
            hold_v_q    <= hold_v_d;
            hold_ch_q   <= hold_ch_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = hold_data_q;
    assign out_last  = hold_last_q;
    assign busy      = (st_q == StLock) | hold_v_q;

endmodule

// File: tb/tb_demux16.sv
// Self-checking bench for demux16: directed scenarios plus randomized traffic,
// checked against a packet-level scoreboard (queue of routed beats).
module tb_demux16;

    localparam int unsigned DW = 64;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic [3:0]    sel;
    logic [15:0]   out_valid;
    logic [15:0]   out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;

    demux16 #(.DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .sel      (sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    ch;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    // Reference: beats routed but not yet delivered, plus the open-packet channel.
    beat_t      sb[$];
    bit         m_open;
    logic [3:0] m_ch;

    int n_checks;
    int n_fail;

    logic [15:0]   obs_valid;
    logic [DW-1:0] obs_data;
    logic          obs_last;
    logic          obs_ready;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_open = 1'b0;
        m_ch   = 4'd0;
    endtask

    // One clock: drive at negedge, compare against the scoreboard, then advance it.
    task automatic cycle(input logic v, input logic [3:0] s, input logic [DW-1:0] d,
                         input logic l, input logic [15:0] r);
        logic [15:0]   e_valid;
        logic [DW-1:0] e_data;
        logic          e_last;
        logic          e_ready;
        logic          e_busy;
        bit            acc;
        bit            drn;
        beat_t         b;
        @(negedge clk);
        in_valid  = v;
        sel       = s;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        #1;
        e_valid = '0;
        e_ready = 1'b1;
        e_data  = obs_data;
        e_last  = obs_last;
        if (sb.size() > 0) begin
            e_valid = 16'd1 << sb[0].ch;
            e_data  = sb[0].data;
            e_last  = sb[0].last;
            e_ready = r[sb[0].ch];
        end
        e_busy    = m_open || (sb.size() > 0);
        obs_valid = out_valid;
        obs_data  = out_data;
        obs_last  = out_last;
        obs_ready = in_ready;
        check("out_valid", {48'd0, out_valid}, {48'd0, e_valid});
        check("in_ready", {63'd0, in_ready}, {63'd0, e_ready});
        check("busy", {63'd0, busy}, {63'd0, e_busy});
        if (sb.size() > 0) begin
            check("out_data", out_data, e_data);
            check("out_last", {63'd0, out_last}, {63'd0, e_last});
        end
        acc = v && e_ready;
        drn = (sb.size() > 0) && r[sb[0].ch];
        @(posedge clk);
        if (drn) void'(sb.pop_front());
        if (acc) begin
            b.ch   = m_open ? m_ch : s;
            b.data = d;
            b.last = l;
            sb.push_back(b);
            if (!m_open && !l) begin
                m_open = 1'b1;
                m_ch   = s;
            end else if (m_open && l) begin
                m_open = 1'b0;
            end
        end
    endtask

    task automatic reset_pulse(input int cycles);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        #1;
        check("rst_out_valid", {48'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_last", {63'd0, out_last}, 64'd0);
        model_reset();
        repeat (cycles) @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] held;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = '0;
        in_last   = 1'b0;
        sel       = '0;
        out_ready = '0;
        obs_data  = '0;
        obs_last  = 1'b0;
        model_reset();

        reset_pulse(3);

        // Sweep all channels with single-beat packets, no stalls.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 4'(i), 64'(i), 1'b1, 16'hFFFF);
            check("sweep_ready", {63'd0, obs_ready}, 64'd1);
            if (i > 0) begin
                check("sweep_valid", {48'd0, obs_valid}, 64'd1 << (i - 1));
                check("sweep_data", obs_data, 64'(i - 1));
            end
        end
        cycle(1'b0, 4'd0, '0, 1'b0, 16'hFFFF);
        check("sweep_valid_last", {48'd0, obs_valid}, 64'h8000);
        cycle(1'b0, 4'd0, '0, 1'b0, 16'hFFFF);

        // Packet lock: sel changes after beat 0 are ignored.
        cycle(1'b1, 4'd3, 64'hA0, 1'b0, 16'hFFFF);
        for (int i = 1; i < 4; i++) begin
            cycle(1'b1, 4'd9, 64'hA0 + 64'(i), (i == 3), 16'hFFFF);
            check("lock_valid", {48'd0, obs_valid}, 64'h0008);
            check("lock_last", {63'd0, obs_last}, 64'd0);
        end
        cycle(1'b0, 4'd9, '0, 1'b0, 16'hFFFF);
        check("lock_valid3", {48'd0, obs_valid}, 64'h0008);
        check("lock_last3", {63'd0, obs_last}, 64'd1);
        cycle(1'b0, 4'd0, '0, 1'b0, 16'hFFFF);

        // Backpressure on channel 5 with every other ready high.
        cycle(1'b1, 4'd5, 64'hDEAD_BEEF, 1'b1, 16'hFFDF);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 4'd5, 64'h1234, 1'b1, 16'hFFDF);
            check("bp_valid", {48'd0, obs_valid}, 64'h0020);
            check("bp_data", obs_data, 64'hDEAD_BEEF);
            check("bp_ready", {63'd0, obs_ready}, 64'd0);
        end
        cycle(1'b1, 4'd5, 64'h1234, 1'b1, 16'hFFFF);
        check("bp_release_ready", {63'd0, obs_ready}, 64'd1);
        cycle(1'b0, 4'd0, '0, 1'b0, 16'hFFFF);
        check("bp_next_data", obs_data, 64'h1234);
        cycle(1'b0, 4'd0, '0, 1'b0, 16'hFFFF);

        // Channel switch without a bubble.
        cycle(1'b1, 4'd2, 64'h20, 1'b0, 16'hFFFF);
        cycle(1'b1, 4'd0, 64'h21, 1'b1, 16'hFFFF);
        check("sw_valid0", {48'd0, obs_valid}, 64'h0004);
        cycle(1'b1, 4'd14, 64'h30, 1'b1, 16'hFFFF);
        check("sw_valid1", {48'd0, obs_valid}, 64'h0004);
        cycle(1'b0, 4'd0, '0, 1'b0, 16'hFFFF);
        check("sw_valid2", {48'd0, obs_valid}, 64'h4000);
        cycle(1'b0, 4'd0, '0, 1'b0, 16'hFFFF);

        // Reset in the middle of a packet to channel 7.
        cycle(1'b1, 4'd7, 64'h70, 1'b0, 16'hFFFF);
        cycle(1'b1, 4'd7, 64'h71, 1'b0, 16'hFFFF);
        reset_pulse(1);
        cycle(1'b1, 4'd1, 64'h10, 1'b1, 16'hFFFF);
        check("mid_rst_ready", {63'd0, obs_ready}, 64'd1);
        cycle(1'b0, 4'd0, '0, 1'b0, 16'hFFFF);
        check("mid_rst_valid", {48'd0, obs_valid}, 64'h0002);

        // Randomized traffic with random per-channel backpressure.
        for (int i = 0; i < 3000; i++) begin
            held = {$urandom, $urandom};
            cycle(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), held,
                  1'($urandom_range(0, 2) == 0),
                  16'($urandom) | 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux16.md
# demux16

Packet-aware 1-to-16 stream demultiplexer with a valid/ready handshake, the distribution-side counterpart of the `mux16` selector. It accepts beats from a single upstream stream and routes each packet to one of 16 downstream channels chosen by `sel`. `sel` is sampled on the first beat of a packet and held until `in_last`. Routing goes through a one-entry registered output stage, so every output is a flop and sustained throughput is one beat per cycle.

## Interface
- `DATA_WIDTH`, 64, width of the data path and of `in_data` / `out_data`.
- `clk`  in  1  single clock for the block; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  upstream beat accepted when `in_valid & in_ready`.
- `in_data`  in  DATA_WIDTH  upstream payload.
- `in_last`  in  1  marks the final beat of a packet.
- `sel`  in  4  destination channel; sampled only on a packet's first beat.
- `out_valid`  out  16  one-hot (or zero) valid, bit k means channel k.
- `out_ready`  in  16  per-channel ready; only the bit of the held channel matters.
- `out_data`  out  DATA_WIDTH  payload shared by all channels.
- `out_last`  out  1  last flag of the held beat.
- `busy`  out  1  high while a packet is open (state LOCK) or a beat is held.

## Operation
- Registers:
  - `hold_v`, `hold_ch[3:0]`, `hold_data`, `hold_last`.
  - Packet state `st` in {IDLE, LOCK}.
  - `pkt_ch[3:0]`.
- Accept is `acc = in_valid & in_ready`. Drain is `drn = hold_v & out_ready[hold_ch]`.
- `in_ready = rst_n & (~hold_v | out_ready[hold_ch])`. This is combinational, with no dependency on `in_valid`.
- Destination of an accepted beat: `sel` when `st == IDLE`, `pkt_ch` when `st == LOCK`.
- FSM transitions (taken only on `acc`):
  - IDLE, beat with `in_last = 0`: capture `pkt_ch <= sel`, go to LOCK.
  - IDLE, beat with `in_last = 1`: single-beat packet, stay in IDLE.
  - LOCK, beat with `in_last = 1`: go to IDLE.
  - LOCK, beat with `in_last = 0`: stay in LOCK.
  - Without `acc`, the state holds. `sel` changes while in LOCK are ignored.
- Hold stage update:
  - On `acc`: load `hold_data`, `hold_last` and `hold_ch` with the destination, and set `hold_v = 1`. This applies even if `drn` occurs in the same cycle (replace-on-drain).
  - On `drn` without `acc`: `hold_v <= 0`.
  - Otherwise: hold all values.
- Outputs:
  - `out_valid = hold_v ? (16'b1 << hold_ch) : 0`, registered as a 16-bit one-hot flop vector.
  - `out_data = hold_data`; `out_last = hold_last`.
  - `busy = (st == LOCK) | hold_v`.
- Stability: while `out_valid[k] & ~out_ready[k]`, the values of `out_data`, `out_last` and `out_valid` must not change.
- Back-to-back packets to different channels need no bubble. The first beat of the new packet is accepted in the same cycle the previous last beat drains.

## Timing
- Reset (asynchronous assert, values held while `rst_n = 0`):
  - `out_valid = 0`, `out_data = 0`, `out_last = 0`, `busy = 0`, `in_ready = 0`.
  - `st = IDLE`, `pkt_ch = 0`, `hold_ch = 0`.
- First cycle after `rst_n` rises: `in_ready = 1`.
- Latency is one cycle: a beat accepted at edge N appears on `out_*` after edge N.
- Throughput is one beat per cycle while the target `out_ready` stays high.
- Backpressure: when the held channel's ready is low, `in_ready` drops in the same cycle. At most one beat is buffered.
- `out_ready` bits of channels other than `hold_ch` have no effect, including when one of them is high and the held one is low.
- Reset mid-packet: the held beat is discarded, the FSM returns to IDLE, and the next beat samples `sel` afresh.

## Test plan
- **Reset:** assert `rst_n = 0` with `in_valid = 1` → `out_valid = 16'h0000`, `in_ready = 0`, `busy = 0`. After release, `in_ready = 1` the next cycle.
- **Sweep:** `out_ready = 16'hFFFF`; send 16 single-beat packets with `sel = i` and `in_data = 64'hi`, one per cycle → each cycle `out_valid = 1 << i` and `out_data = i`, one cycle after acceptance, with no stalls.
- **Packet lock:** send a 4-beat packet with `sel = 3` on beat 0, then `sel` changed to 9 on beats 1-3 → all beats appear on `out_valid = 16'h0008`. `out_last = 1` appears only on beat 3. `busy` is high from beat 0 until the hold stage empties.
- **Backpressure:** hold `sel = 5` with `out_ready[5] = 0` and every other ready bit = 1 → `out_valid = 16'h0020`, `out_data` stable, `in_ready = 0`. Raising `out_ready[5]` drains the beat and accepts the next beat in the same cycle.
- **Channel switch:** a 2-beat packet to channel 2 followed immediately by a 1-beat packet to channel 14 → `out_valid` goes `16'h0004`, `16'h0004`, `16'h4000` on consecutive cycles, with no bubble.
- **Reset mid-packet:** pulse `rst_n` low after beat 1 of a 3-beat packet to channel 7 → `out_valid` clears immediately. The next beat, sent with `sel = 1`, routes to `16'h0002`.
